// File: rtl/mux_arb_pkg.sv
// Shared encodings for the two-requester 4-bit mux arbiter.
package mux_arb_pkg;
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G1   = 2'b01,
        G2   = 2'b10
    } state_t;

    typedef enum logic {
        REQ1 = 1'b0,
        REQ2 = 1'b1
    } who_t;
endpackage

// File: rtl/mux21_4.sv
// 2:1 mux over 4-bit data; sel=0 picks in1, sel=1 picks in2.
module mux21_4 (
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       sel,
    output logic [3:0] out
);
    assign out = sel ? in2 : in1;
endmodule

// File: rtl/mux21_4_arb.sv
// Two-requester arbiter with bounded hold, steering a registered 4-bit mux.
import mux_arb_pkg::*;

module mux21_4_arb #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       sel,
    output logic [3:0] out,
    output logic       out_valid
);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t             state;
    state_t             nxt;
    who_t               last;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [3:0]         mux_out;
    logic               hold_done;

    assign hold_done = (hold_cnt == HOLD_LAST);

    mux21_4 u_mux (
        .in1 (in1),
        .in2 (in2),
        .sel (sel),
        .out (mux_out)
    );

    // A grant is only yielded early when the other side is actually waiting.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req1 && (!req2 || last == REQ2)) nxt = G1;
                else if (req2)                       nxt = G2;
                else                                 nxt = IDLE;
            end
            G1: begin
                if (!req1)                nxt = req2 ? G2 : IDLE;
                else if (req2 && hold_done) nxt = G2;
                else                      nxt = G1;
            end
            G2: begin
                if (!req2)                nxt = req1 ? G1 : IDLE;
                else if (req1 && hold_done) nxt = G1;
                else                      nxt = G2;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt1      <= 1'b0;
            gnt2      <= 1'b0;
            sel       <= 1'b0;
            out       <= 4'b0000;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            last      <= REQ2;
        end else begin
            state     <= nxt;
            gnt1      <= (nxt == G1);
            gnt2      <= (nxt == G2);
            out_valid <= gnt1 | gnt2;
            if (state != IDLE) out <= mux_out;
            // sel keeps its last value through IDLE
            if (nxt != IDLE) sel <= (nxt == G2);

            if (nxt == IDLE || nxt != state) hold_cnt <= '0;
            else if (!hold_done)             hold_cnt <= hold_cnt + 1'b1;

            if (nxt != IDLE && nxt != state) last <= (nxt == G2) ? REQ2 : REQ1;
        end
    end
endmodule

// File: tb/tb_mux21_4_arb.sv
// Directed checks of mux21_4_arb at MAX_HOLD=4, with a MAX_HOLD=1 copy alongside.
module tb_mux21_4_arb;
    logic       clk = 1'b0;
    logic       rst;
    logic       req1, req2;
    logic [3:0] in1, in2;
    logic       gnt1, gnt2, sel, out_valid;
    logic [3:0] out_q;
    logic       gnt1_b, gnt2_b, sel_b, out_valid_b;
    logic [3:0] out_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mux21_4_arb #(.MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
        .gnt1(gnt1), .gnt2(gnt2), .sel(sel), .out(out_q), .out_valid(out_valid)
    );

    mux21_4_arb #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req1(req1), .req2(req2), .in1(in1), .in2(in2),
        .gnt1(gnt1_b), .gnt2(gnt2_b), .sel(sel_b), .out(out_b), .out_valid(out_valid_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       exp_g1;
        logic       prev_sel;
        logic [3:0] exp_out;

        // reset with both requests asserted
        rst = 1'b1; req1 = 1'b1; req2 = 1'b1; in1 = 4'h0; in2 = 4'h0;
        tick(); tick();
        chk("rst_gnt1", 8'(gnt1), 8'h0);
        chk("rst_gnt2", 8'(gnt2), 8'h0);
        chk("rst_out", 8'(out_q), 8'h0);
        chk("rst_vld", 8'(out_valid), 8'h0);
        chk("rst_sel", 8'(sel), 8'h0);

        // single requester 1
        rst = 1'b0; req1 = 1'b1; req2 = 1'b0; in1 = 4'b1010;
        tick();
        chk("s1_gnt1", 8'(gnt1), 8'h1);
        chk("s1_sel", 8'(sel), 8'h0);
        chk("s1_vld0", 8'(out_valid), 8'h0);
        tick();
        chk("s1_out", 8'(out_q), 8'ha);
        chk("s1_vld1", 8'(out_valid), 8'h1);
        req1 = 1'b0;
        tick();
        chk("s1_idle", 8'(gnt1), 8'h0);
        in1 = 4'b0101;
        tick();
        chk("s1_hold_out", 8'(out_q), 8'ha);
        chk("s1_hold_vld", 8'(out_valid), 8'h0);
        chk("s1_hold_sel", 8'(sel), 8'h0);

        // tie after reset: 4-cycle slices on dut, 1-cycle slices on dut1
        rst = 1'b1;
        tick();
        rst = 1'b0; req1 = 1'b1; req2 = 1'b1; in1 = 4'b1111; in2 = 4'b0000;
        prev_sel = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_g1  = (((k - 1) / 4) % 2) == 0;
            exp_out = (k == 1) ? 4'b0000 : (prev_sel ? 4'b0000 : 4'b1111);
            chk($sformatf("tie_g1_%0d", k), 8'(gnt1), 8'(exp_g1));
            chk($sformatf("tie_g2_%0d", k), 8'(gnt2), 8'(!exp_g1));
            chk($sformatf("tie_sel_%0d", k), 8'(sel), 8'(!exp_g1));
            chk($sformatf("tie_out_%0d", k), 8'(out_q), 8'(exp_out));
            chk($sformatf("tie_vld_%0d", k), 8'(out_valid), 8'(k != 1));
            chk($sformatf("alt_g1_%0d", k), 8'(gnt1_b), 8'(k % 2));
            chk($sformatf("alt_g2_%0d", k), 8'(gnt2_b), 8'((k + 1) % 2));
            prev_sel = !exp_g1;
        end

        // requester 2 alone for 10 cycles, then requester 1 joins
        rst = 1'b1;
        tick();
        rst = 1'b0; req1 = 1'b0; req2 = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("solo_g2_%0d", k), 8'(gnt2), 8'h1);
            chk($sformatf("solo_g1_%0d", k), 8'(gnt1), 8'h0);
            chk($sformatf("solo_hold_%0d", k), 8'(dut.hold_cnt), 8'((k > 4) ? 3 : k - 1));
        end
        req1 = 1'b1;
        tick();
        chk("force_g1", 8'(gnt1), 8'h1);
        chk("force_g2", 8'(gnt2), 8'h0);

        // handover on release: G1 -> G2 with no IDLE in between
        rst = 1'b1;
        tick();
        rst = 1'b0; req1 = 1'b1; req2 = 1'b0;
        tick();
        chk("ho_g1", 8'(gnt1), 8'h1);
        req1 = 1'b0; req2 = 1'b1;
        tick();
        chk("ho_g2", 8'(gnt2), 8'h1);
        chk("ho_g1_off", 8'(gnt1), 8'h0);
        chk("ho_sel", 8'(sel), 8'h1);

        // reset mid-grant, then both request
        req1 = 1'b1; rst = 1'b1;
        tick();
        chk("mid_g2", 8'(gnt2), 8'h0);
        chk("mid_g1", 8'(gnt1), 8'h0);
        chk("mid_vld", 8'(out_valid), 8'h0);
        chk("mid_sel", 8'(sel), 8'h0);
        rst = 1'b0;
        tick();
        chk("mid_win", 8'(gnt1), 8'h1);
        chk("mid_lose", 8'(gnt2), 8'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mux21_4_arb.md
MUX21_4_ARB -- requirements
Module: mux21_4_arb

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 4, giving the maximum consecutive grant cycles while the other requester waits; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port req1, input, 1, request from requester 1.
REQ-005 SHALL have port req2, input, 1, request from requester 2.
REQ-006 SHALL have port in1, input, 4, data from requester 1.
REQ-007 SHALL have port in2, input, 4, data from requester 2.
REQ-008 SHALL have port gnt1, output, 1, grant to requester 1 (registered).
REQ-009 SHALL have port gnt2, output, 1, grant to requester 2 (registered).
REQ-010 SHALL have port sel, output, 1, mux select: 0 = in1, 1 = in2 (registered).
REQ-011 SHALL have port out, output, 4, registered muxed data.
REQ-012 SHALL have port out_valid, output, 1, high when out holds granted data.

Function
REQ-013 SHALL implement FSM states IDLE, G1, G2; gnt1 = (state==G1), gnt2 = (state==G2); never both high.
REQ-014 IDLE: req1 only -> G1; req2 only -> G2; both -> the requester not granted last (last pointer); neither -> stay IDLE.
REQ-015 Grant latency SHALL be one cycle: req sampled high at edge N in IDLE gives gnt high from edge N onward (visible the cycle after req first seen).
REQ-016 G1: req1 low -> G2 if req2 else IDLE; req1 high, req2 high, hold_cnt==MAX_HOLD-1 -> G2; otherwise stay G1. G2 symmetric.
REQ-017 hold_cnt (4 bits) SHALL clear on every entry to G1/G2 and on IDLE, increment each cycle in a grant state, saturate at MAX_HOLD-1.
REQ-018 Forced handover: losing requester with req still high SHALL be re-granted no earlier than after the other grant ends (no back-to-back starvation).
REQ-019 last pointer SHALL update to the granted requester on each entry to G1/G2.
REQ-020 sel SHALL be 0 in G1, 1 in G2, and hold its previous value in IDLE.
REQ-021 out SHALL capture mux(in1,in2,sel) each edge where state is G1/G2, so data presented while gnt is high appears one cycle later; out holds in IDLE.
REQ-022 out_valid SHALL equal the previous cycle's (gnt1|gnt2).
REQ-023 MAX_HOLD=1 SHALL alternate every cycle when both requests stay high.

Reset
REQ-024 On rst high at an edge: state IDLE, gnt1=gnt2=0, sel=0, out=4'b0000, out_valid=0, hold_cnt=0, last pointer=requester 2 (first tie goes to req1).
REQ-025 rst mid-grant SHALL abort the grant at that edge; rst has priority over all requests.

Structure
REQ-026 State encodings (IDLE=2'b00, G1=2'b01, G2=2'b10) and hold counter width SHALL live in shared package mux_arb_pkg.
REQ-027 Data path SHALL instantiate the existing mux21_4 (in1, in2, sel, out) as the single sub-module, feeding the out register.

Verification
REQ-028 Reset: rst=1 two cycles with req1=req2=1 -> gnt1=gnt2=0, out=0000, out_valid=0, sel=0.
REQ-029 Single requester: req1=1, in1=1010 -> gnt1 next cycle, sel=0, out=1010 with out_valid=1 one cycle later; drop req1 -> IDLE, out holds 1010.
REQ-030 Tie after reset: req1=req2=1, in1=1111, in2=0000, MAX_HOLD=4 -> G1 for 4 cycles, then G2 for 4 cycles, alternating; out follows 1111/0000 one cycle behind sel.
REQ-031 No contention: req2 alone held 10 cycles -> gnt2 stays high all 10 cycles, hold_cnt saturates at 3.
REQ-032 Handover on release: in G1, req1 falls while req2=1 -> G2 on the next edge, no IDLE cycle.
REQ-033 Reset mid-grant: rst pulsed while gnt2=1 -> gnt2=0 next edge; with both requests high afterwards, gnt1 wins.
